// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: Rijndael ShiftRows / InvShiftRows for NB = 4, 6, 8
// columns, with a 2-entry output FIFO and valid/ready handshakes.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of buffered blocks)
//   in_valid/in_ready/in_inv/in_state     : upstream block interface
//   out_valid/out_ready/out_inv/out_state : downstream block interface
//   blk_cnt (only with AES_SHIFT_ROWS_CNT_EN) : popped-block counter
module aes_shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inv,
    input  logic [NB*4*BYTE_W-1:0]   in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_inv,
`ifdef AES_SHIFT_ROWS_CNT_EN
    output logic [31:0]              blk_cnt,
`endif
    output logic [NB*4*BYTE_W-1:0]   out_state
);

    localparam int W = NB * 4 * BYTE_W;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row offsets; the 8-column block uses the wider Rijndael schedule.
    function automatic int row_off(input int r);
        if (NB == 8) begin
            case (r)
                0:       return 0;
                1:       return 1;
                2:       return 3;
                default: return 4;
            endcase
        end
        return r;
    endfunction

    logic [W-1:0] fwd_w;
    logic [W-1:0] inv_w;
    logic [W-1:0] shifted_w;

    // Source columns are resolved at elaboration: pure wiring.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = row_off(r);
            localparam int FS  = (c + OFF) % NB;
            localparam int IS  = (c - OFF + NB) % NB;
            assign fwd_w[(c*4+r)*BYTE_W +: BYTE_W] =
                in_state[(FS*4+r)*BYTE_W +: BYTE_W];
            assign inv_w[(c*4+r)*BYTE_W +: BYTE_W] =
                in_state[(IS*4+r)*BYTE_W +: BYTE_W];
        end
    end

    assign shifted_w = in_inv ? inv_w : fwd_w;

    logic [W-1:0] mem_q [2];
    logic         minv_q [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_state = mem_q[rd_q];
    assign out_inv   = minv_q[rd_q];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            minv_q[0] <= 1'b0;
            minv_q[1] <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push && !flush) begin
                mem_q[wr_q]  <= shifted_w;
                minv_q[wr_q] <= in_inv;
            end
        end
    end

`ifdef AES_SHIFT_ROWS_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    // A pop squashed by flush is not a delivered block.
    assign blk_cnt_d = (pop && !flush) ? blk_cnt_q + 32'd1 : blk_cnt_q;
    assign blk_cnt   = blk_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blk_cnt_q <= '0;
        else     blk_cnt_q <= blk_cnt_d;
    end
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: NB=4 instance checked each cycle against a
// queue model, NB=8 instance checked with directed vectors.
module tb_aes_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, in_inv, out_ready;
    logic         in_ready, out_valid, out_inv;
    logic [127:0] in_state, out_state;

    logic         in_valid8, in_inv8, in_ready8, out_valid8, out_inv8;
    logic         flush8, out_ready8;
    logic [255:0] in_state8, out_state8;
`ifdef AES_SHIFT_ROWS_CNT_EN
    logic [31:0]  blk_cnt, blk_cnt8;
`endif

    aes_shift_rows_pipe #(.NB(4), .BYTE_W(8)) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
`ifdef AES_SHIFT_ROWS_CNT_EN
        .blk_cnt(blk_cnt),
`endif
        .out_state(out_state)
    );

    aes_shift_rows_pipe #(.NB(8), .BYTE_W(8)) u8 (
        .clk(clk), .rst(rst), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
        .in_state(in_state8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_inv(out_inv8),
`ifdef AES_SHIFT_ROWS_CNT_EN
        .blk_cnt(blk_cnt8),
`endif
        .out_state(out_state8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference ShiftRows straight from the Rijndael definition.
    function automatic logic [255:0] ref_shift(input logic [255:0] s,
                                               input int nb, input bit inv);
        int off [4];
        int src;
        logic [255:0] o;
        o = '0;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - off[r] + nb) % nb;
                else     src = (c + off[r]) % nb;
                o[(c*4+r)*8 +: 8] = s[(src*4+r)*8 +: 8];
            end
        end
        return o;
    endfunction

    // Queue model of the NB=4 instance: {inv, state} per buffered block.
    logic [128:0] q [$];
    int           mcnt = 0;
    logic [255:0] mtmp;
    bit           m_pu, m_po;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            m_pu = in_valid && (q.size() != 2);
            m_po = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_po) begin
                    void'(q.pop_front());
                    mcnt++;
                end
                if (m_pu) begin
                    mtmp = ref_shift({128'd0, in_state}, 4, in_inv);
                    q.push_back({in_inv, mtmp[127:0]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_in_ready", in_ready, q.size() != 2);
            chk("cmp_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("cmp_out_state", out_state, q[0][127:0]);
                chk("cmp_out_inv", out_inv, q[0][128]);
            end
`ifdef AES_SHIFT_ROWS_CNT_EN
            chk("cmp_blk_cnt", blk_cnt, mcnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] a4, fwd4, blk_a, blk_b, blk_c;
    logic [255:0] a8, f8, t;
    logic [7:0]   lit [16];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
        in_state = '0; out_ready = 1'b1;
        flush8 = 1'b0; in_valid8 = 1'b0; in_inv8 = 1'b0;
        in_state8 = '0; out_ready8 = 1'b1;

        lit = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
        for (int i = 0; i < 16; i++) begin
            a4[i*8 +: 8]   = 8'(i);
            fwd4[i*8 +: 8] = lit[i];
        end
        for (int i = 0; i < 32; i++) a8[i*8 +: 8] = 8'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_state", out_state, 0);
        chk("rst_out_inv", out_inv, 0);
        chk("rst_out_state8", out_state8, 0);
        step();
        rst = 1'b0;

        t = ref_shift({128'd0, a4}, 4, 1'b0);
        chk("model_fwd4", t[127:0], fwd4);

        // forward NB=4
        in_valid = 1'b1; in_state = a4; in_inv = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fwd4_valid", out_valid, 1);
        chk("fwd4_state", out_state, fwd4);
        chk("fwd4_inv", out_inv, 0);

        // inverse round trip
        in_valid = 1'b1; in_state = fwd4; in_inv = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("inv4_state", out_state, a4);
        chk("inv4_inv", out_inv, 1);

        // back-to-back alternating modes
        step();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_inv   = k[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        step();

        // backpressure with three blocks
        blk_a = {4{32'hA0A1A2A3}} ^ a4;
        blk_b = {4{32'hB0B1B2B3}} ^ a4;
        blk_c = {4{32'hC0C1C2C3}} ^ a4;
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = blk_a; in_inv = 1'b0;
        step();
        in_state = blk_b; in_inv = 1'b1;
        step();
        in_state = blk_c; in_inv = 1'b0;
        @(negedge clk);
        t = ref_shift({128'd0, blk_a}, 4, 1'b0);
        chk("bp_ready_low", in_ready, 0);
        chk("bp_head_a", out_state, t[127:0]);
        step();
        @(negedge clk);
        chk("bp_ready_held", in_ready, 0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        t = ref_shift({128'd0, blk_b}, 4, 1'b1);
        chk("bp_head_b", out_state, t[127:0]);
        chk("bp_ready_up", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        t = ref_shift({128'd0, blk_c}, 4, 1'b0);
        chk("bp_head_c", out_state, t[127:0]);
        chk("bp_c_valid", out_valid, 1);
        step();
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // flush at count 2 with a concurrent input
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = blk_a;
        step();
        in_state = blk_b;
        step();
        flush = 1'b1; out_ready = 1'b1; in_state = blk_c;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        step();
        @(negedge clk);
        chk("flush_no_emit", out_valid, 0);

        // NB=8 forward and inverse
        in_valid8 = 1'b1; in_state8 = a8; in_inv8 = 1'b0;
        step();
        in_valid8 = 1'b0;
        @(negedge clk);
        f8 = ref_shift(a8, 8, 1'b0);
        chk("nb8_col0", out_state8[31:0], 32'h130E0500);
        chk("nb8_col7", out_state8[255:224], 32'h0F0A011C);
        chk("model_nb8_col0", f8[31:0], 32'h130E0500);
        chk("nb8_full", out_state8, f8);
        in_valid8 = 1'b1; in_state8 = f8; in_inv8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("nb8_roundtrip", out_state8, a8);
        chk("nb8_inv", out_inv8, 1);

        // async reset between edges
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = blk_b; in_inv = 1'b1;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_state", out_state, 0);
        chk("arst_inv", out_inv, 0);
        chk("arst_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

`ifdef AES_SHIFT_ROWS_CNT_EN
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_state = a4 ^ 128'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_state = a4 ^ 128'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("cnt_seven", blk_cnt, 32'd7);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
